// File: rtl/axis_dma_pkg.sv
// Shared definitions for the axis_dma_rd read DMA.
// Holds the controller state encoding and the default bus widths.
package axis_dma_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W  = 32;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    FIN
  } state_t;

endpackage

// File: rtl/axis_dma_rd_out_reg.sv
// Single-entry AXI4-Stream output holding register for axis_dma_rd.
// Loads on a memory response and clears on the stream handshake.
// TDATA (and TLAST) hold steady while the consumer stalls.
// Optional feature macro: AXIS_DMA_RD_TLAST_EN adds the load_last input and the tlast output.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load, load_data capture a new beat (load_last marks the final beat)
//   tready          consumer ready
//   tvalid, tdata   held beat (tlast when enabled)
module axis_dma_rd_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
`ifdef AXIS_DMA_RD_TLAST_EN
  input  logic              load_last,
  output logic              tlast,
`endif
  input  logic              tready,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
`ifdef AXIS_DMA_RD_TLAST_EN
      tlast  <= 1'b0;
`endif
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
`ifdef AXIS_DMA_RD_TLAST_EN
      tlast  <= load_last;
`endif
    end else if (tvalid && tready) begin
      // tdata keeps its last value; only the qualifiers drop
      tvalid <= 1'b0;
`ifdef AXIS_DMA_RD_TLAST_EN
      tlast  <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/axis_dma_rd.sv
// Single-channel memory-to-stream read DMA.
// On an accepted start it reads `length` bytes from base_addr upward. Each byte is
// emitted as one AXIS beat, and one memory read is outstanding at a time.
// Optional feature macro: AXIS_DMA_RD_TLAST_EN adds M_AXIS_TLAST on the final beat.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, base_addr, length     transfer command (sampled in IDLE)
//   done                         one-cycle completion pulse
//   mem_rd_valid, mem_rd_addr    read request
//   mem_rd_resp_valid/_data      read response (latency >= 1)
//   M_AXIS_TVALID/TDATA/TREADY   stream master (M_AXIS_TLAST when enabled)
module axis_dma_rd
  import axis_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              done,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_resp_valid,
  input  logic [DATA_W-1:0] mem_rd_resp_data,
  output logic              M_AXIS_TVALID,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
`ifdef AXIS_DMA_RD_TLAST_EN
  output logic              M_AXIS_TLAST,
`endif
  input  logic              M_AXIS_TREADY
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              done_q;
  logic              load;
  logic              hs;
  logic              last_beat;

  assign hs           = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last_beat    = (rem_q == LEN_W'(1));
  assign mem_rd_valid = (state_q == REQ);
  assign mem_rd_addr  = addr_q;
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = (length == '0) ? FIN : REQ;
      REQ:  state_d = WAIT;
      WAIT: if (mem_rd_resp_valid) begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: if (hs) state_d = last_beat ? FIN : REQ;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // registered off FIN so the pulse lands two cycles after a zero-length start
      // and never overlaps the last beat's TVALID
      done_q  <= (state_q == FIN);
      if (state_q == IDLE && start) begin
        addr_q <= base_addr;
        rem_q  <= length;
      end else if (state_q == SEND && hs) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
    end
  end

  axis_dma_rd_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (mem_rd_resp_data),
`ifdef AXIS_DMA_RD_TLAST_EN
    .load_last (last_beat),
    .tlast     (M_AXIS_TLAST),
`endif
    .tready    (M_AXIS_TREADY),
    .tvalid    (M_AXIS_TVALID),
    .tdata     (M_AXIS_TDATA)
  );

endmodule

// File: tb/tb_axis_dma_rd.sv
// Self-checking bench for axis_dma_rd. A behavioural memory with programmable latency
// returns addr[7:0]^mem_xor, and a monitor collects beats, requests and done pulses.
// The expected byte stream is computed directly from base/length.
module tb_axis_dma_rd;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] length;
  logic        done;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_resp_valid;
  logic [7:0]  mem_rd_resp_data;
  logic        M_AXIS_TVALID;
  logic [7:0]  M_AXIS_TDATA;
  logic        M_AXIS_TREADY;
  logic        tlast;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_dma_rd dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .length            (length),
    .done              (done),
    .mem_rd_valid      (mem_rd_valid),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_resp_valid (mem_rd_resp_valid),
    .mem_rd_resp_data  (mem_rd_resp_data),
    .M_AXIS_TVALID     (M_AXIS_TVALID),
    .M_AXIS_TDATA      (M_AXIS_TDATA),
`ifdef AXIS_DMA_RD_TLAST_EN
    .M_AXIS_TLAST      (tlast),
`endif
    .M_AXIS_TREADY     (M_AXIS_TREADY)
  );
`ifndef AXIS_DMA_RD_TLAST_EN
  assign tlast = 1'b0;
`endif

  // ---------------- memory model ----------------
  int          mem_lat = 1;
  logic [7:0]  mem_xor = 8'h00;
  logic        rq;
  logic [31:0] ra;
  bit          pend = 0;
  int          pcnt;
  logic [31:0] paddr;

  function automatic logic [7:0] exp_byte(input logic [31:0] a);
    return a[7:0] ^ mem_xor;
  endfunction

  always @(posedge clk) begin
    rq = mem_rd_valid;
    ra = mem_rd_addr;
    #1;
    mem_rd_resp_valid = 1'b0;
    mem_rd_resp_data  = 8'($urandom);
    if (!rst_n) pend = 0;
    else begin
      if (rq) begin pend = 1; pcnt = mem_lat; paddr = ra; end
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          pend = 0;
          mem_rd_resp_valid = 1'b1;
          mem_rd_resp_data  = exp_byte(paddr);
        end
      end
    end
  end

  // ---------------- consumer ----------------
  bit rdy_rand = 0;
  always @(posedge clk) begin
    #2;
    M_AXIS_TREADY = rdy_rand ? 1'($urandom) : 1'b1;
  end

  // ---------------- monitor ----------------
  logic [7:0]  got_q[$];
  logic        last_q[$];
  logic [31:0] req_q[$];
  int          done_cnt, stab_err, done_tv_err;
  bit          prev_stall = 0;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!M_AXIS_TVALID || M_AXIS_TDATA !== prev_data)) stab_err++;
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got_q.push_back(M_AXIS_TDATA);
        last_q.push_back(tlast);
      end
      if (mem_rd_valid) req_q.push_back(mem_rd_addr);
      if (done) begin
        done_cnt++;
        if (M_AXIS_TVALID) done_tv_err++;
      end
    end else prev_stall = 0;
  end

  // Issues one command and waits (bounded) for done; cyc counts edges after the start edge.
  task automatic run_xfer(input logic [31:0] b, input logic [31:0] l, input int lat,
                          input bit rr, input int restart_at, output int cyc, output bit to);
    int limit;
    got_q.delete(); last_q.delete(); req_q.delete();
    done_cnt = 0; stab_err = 0; done_tv_err = 0;
    mem_lat = lat; rdy_rand = rr;
    limit = (int'(l) + 1) * (lat + 40) + 20;
    @(negedge clk);
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; length = $urandom;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == restart_at) begin start = 1'b1; base_addr = $urandom; length = 3; end
      if (cyc == restart_at + 1) start = 1'b0;
    end while (!done && cyc < limit);
    to = !done;
    start = 1'b0;
    repeat (6) @(negedge clk);
    rdy_rand = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({done, mem_rd_valid, M_AXIS_TVALID, tlast} !== 4'b0) begin
      fails++; $display("FAIL reset_flags got %b want 0000", {done, mem_rd_valid, M_AXIS_TVALID, tlast});
    end
    tests++;
    if (mem_rd_addr !== 32'h0 || M_AXIS_TDATA !== 8'h0) begin
      fails++; $display("FAIL reset_regs got addr=%h tdata=%h want 0", mem_rd_addr, M_AXIS_TDATA);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({done, mem_rd_valid, M_AXIS_TVALID} !== 3'b0) begin
      fails++; $display("FAIL idle_after_reset got %b want 000", {done, mem_rd_valid, M_AXIS_TVALID});
    end
  endtask

  task automatic test_basic();
    int cyc; bit to;
    mem_xor = 8'h00;
    run_xfer(32'h0, 32, 1, 0, -1, cyc, to);
    tests++;
    if (to || cyc != 3 * 32 + 1) begin
      fails++; $display("FAIL basic_latency got %0d cycles (timeout=%0d) want %0d", cyc, to, 3 * 32 + 1);
    end
    tests++;
    if (got_q.size() != 32 || done_cnt != 1 || req_q.size() != 32) begin
      fails++; $display("FAIL basic_counts got beats=%0d done=%0d reqs=%0d want 32/1/32",
                        got_q.size(), done_cnt, req_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 32; i++) begin
      tests++;
      if (got_q[i] !== 8'(i)) begin
        fails++; $display("FAIL basic_data[%0d] got %h want %h", i, got_q[i], 8'(i));
      end
    end
    tests++;
    if (done_tv_err != 0) begin
      fails++; $display("FAIL done_with_tvalid got %0d want 0", done_tv_err);
    end
  endtask

  task automatic test_stall();
    int cyc; bit to;
    run_xfer(32'h0, 32, 1, 1, -1, cyc, to);
    tests++;
    if (to || got_q.size() != 32 || req_q.size() != 32 || done_cnt != 1) begin
      fails++; $display("FAIL stall_counts got beats=%0d reqs=%0d done=%0d to=%0d want 32/32/1/0",
                        got_q.size(), req_q.size(), done_cnt, to);
    end
    tests++;
    if (stab_err != 0) begin
      fails++; $display("FAIL stall_stability got %0d violations want 0", stab_err);
    end
    for (int i = 0; i < got_q.size() && i < 32; i++) begin
      tests++;
      if (got_q[i] !== 8'(i) || req_q[i] !== 32'(i)) begin
        fails++; $display("FAIL stall_beat[%0d] got data=%h addr=%h want %h", i, got_q[i], req_q[i], 8'(i));
      end
    end
  endtask

  task automatic test_zero_len();
    int cyc; bit to;
    run_xfer(32'h1234, 0, 1, 0, -1, cyc, to);
    tests++;
    if (to || cyc != 1 || done_cnt != 1) begin
      fails++; $display("FAIL zero_len_done got cyc=%0d done=%0d to=%0d want 1/1/0", cyc, done_cnt, to);
    end
    tests++;
    if (req_q.size() != 0 || got_q.size() != 0) begin
      fails++; $display("FAIL zero_len_activity got reqs=%0d beats=%0d want 0/0", req_q.size(), got_q.size());
    end
  endtask

  task automatic test_wrap();
    int cyc; bit to;
    logic [31:0] exp_a[4];
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    mem_xor = 8'h5A;
    run_xfer(32'hFFFF_FFFE, 4, 1, 0, -1, cyc, to);
    tests++;
    if (to || req_q.size() != 4 || got_q.size() != 4) begin
      fails++; $display("FAIL wrap_counts got reqs=%0d beats=%0d to=%0d want 4/4/0", req_q.size(), got_q.size(), to);
    end
    for (int i = 0; i < req_q.size() && i < 4; i++) begin
      tests++;
      if (req_q[i] !== exp_a[i] || got_q[i] !== exp_byte(exp_a[i])) begin
        fails++; $display("FAIL wrap_addr[%0d] got %h/%h want %h/%h", i, req_q[i], got_q[i],
                          exp_a[i], exp_byte(exp_a[i]));
      end
    end
  endtask

  task automatic test_restart();
    int cyc; bit to;
    logic [31:0] b;
    b = 32'h0000_1F00 + 32'($urandom_range(0, 255));
    mem_xor = 8'($urandom);
    run_xfer(b, 6, 3, 0, 7, cyc, to);
    tests++;
    if (to || done_cnt != 1 || got_q.size() != 6 || req_q.size() != 6) begin
      fails++; $display("FAIL restart_counts got done=%0d beats=%0d reqs=%0d to=%0d want 1/6/6/0",
                        done_cnt, got_q.size(), req_q.size(), to);
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      tests++;
      if (got_q[i] !== exp_byte(b + 32'(i))) begin
        fails++; $display("FAIL restart_data[%0d] got %h want %h", i, got_q[i], exp_byte(b + 32'(i)));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; int n;
    logic [31:0] b;
    mem_xor = 8'h00;
    got_q.delete(); done_cnt = 0; mem_lat = 1; rdy_rand = 0;
    @(negedge clk);
    base_addr = 32'h100; length = 32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(got_q.size() == 9 && M_AXIS_TVALID) && n < 200) begin
      @(posedge clk); #3; n++;
    end
    tests++;
    if (n >= 200) begin
      fails++; $display("FAIL reset_mid_reach got beats=%0d want beat 10 pending", got_q.size());
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({done, mem_rd_valid, M_AXIS_TVALID, tlast} !== 4'b0 || mem_rd_addr !== 32'h0 || M_AXIS_TDATA !== 8'h0) begin
      fails++; $display("FAIL reset_mid_async got flags=%b addr=%h tdata=%h want 0",
                        {done, mem_rd_valid, M_AXIS_TVALID, tlast}, mem_rd_addr, M_AXIS_TDATA);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt != 0) begin
      fails++; $display("FAIL reset_mid_no_done got %0d want 0", done_cnt);
    end
    b = $urandom;
    run_xfer(b, 4, 2, 1, -1, cyc, to);
    tests++;
    if (to || done_cnt != 1 || got_q.size() != 4) begin
      fails++; $display("FAIL post_reset_counts got done=%0d beats=%0d to=%0d want 1/4/0", done_cnt, got_q.size(), to);
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      tests++;
      if (got_q[i] !== exp_byte(b + 32'(i))) begin
        fails++; $display("FAIL post_reset_data[%0d] got %h want %h", i, got_q[i], exp_byte(b + 32'(i)));
      end
`ifdef AXIS_DMA_RD_TLAST_EN
      tests++;
      if (last_q[i] !== (i == 3)) begin
        fails++; $display("FAIL tlast[%0d] got %b want %b", i, last_q[i], (i == 3));
      end
`endif
    end
  endtask

  task automatic test_random();
    int cyc; bit to; int l; int lat;
    logic [31:0] b;
    for (int t = 0; t < 4; t++) begin
      b = $urandom; l = $urandom_range(1, 12); lat = $urandom_range(1, 4);
      mem_xor = 8'($urandom);
      run_xfer(b, 32'(l), lat, 1, -1, cyc, to);
      tests++;
      if (to || done_cnt != 1 || got_q.size() != l || req_q.size() != l || stab_err != 0) begin
        fails++; $display("FAIL random%0d_counts got done=%0d beats=%0d reqs=%0d stab=%0d to=%0d want 1/%0d/%0d/0/0",
                          t, done_cnt, got_q.size(), req_q.size(), stab_err, to, l, l);
      end
      for (int i = 0; i < got_q.size() && i < l; i++) begin
        tests++;
        if (got_q[i] !== exp_byte(b + 32'(i))) begin
          fails++; $display("FAIL random%0d_data[%0d] got %h want %h", t, i, got_q[i], exp_byte(b + 32'(i)));
        end
      end
    end
  endtask

  initial begin
    M_AXIS_TREADY = 1'b1;
    mem_rd_resp_valid = 1'b0;
    mem_rd_resp_data = 8'h0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_wrap();
    test_restart();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
